// File: rtl/lane_arbiter_if.sv
// Shared-lane bundle: per-requester request/beat inputs, grant status, and the single
// downstream beat stream with its source index.
interface lane_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 1
);
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] in_data;
    logic [NREQ-1:0]       in_ready;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SW-1:0]         out_src;
    logic                  out_ready;

    modport master (
        output req, in_data, out_ready,
        input  in_ready, gnt, busy, out_valid, out_data, out_src
    );

    modport slave (
        input  req, in_data, out_ready,
        output in_ready, gnt, busy, out_valid, out_data, out_src
    );
endinterface

// File: rtl/lane_arbiter.sv
// Round-robin owner of one pass-through lane; granted requester streams beats through s0/s1.
// Latency: grant one cycle after request, beat reaches out_valid two edges after acceptance.
// Backpressure: out_ready stalls s1 then s0; in_ready drops when both are full, grant is held.
module lane_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    lane_arbiter_if.slave    bus
);
    localparam int SW = $clog2(NREQ);

    typedef enum logic {IDLE, OWN} state_t;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] dat;
        logic [SW-1:0]    src;
    } stage_t;

    state_t            state, state_n;
    logic [SW-1:0]     g, rr_ptr, pick, g_inc;
    logic [NREQ-1:0]   pick_oh;
    logic [7:0]        cnt;
    logic [NREQ-1:0]   gnt_q;
    logic              busy_q;
    stage_t            s0, s1;

    logic              any_req, req_g, s1_load, s0_free, accept, release_own, last_beat;
    logic [WIDTH-1:0]  g_dat;
    logic [NREQ-1:0]   in_rdy;
    logic [2*NREQ-1:0] req_rot;
    int                pidx;

    assign any_req   = |bus.req;
    assign s1_load   = s0.vld && (!s1.vld || bus.out_ready);
    assign s0_free   = !s0.vld || s1_load;
    assign last_beat = (cnt == 8'(MAX_BURST - 1));
    assign g_inc     = (int'(g) == NREQ - 1) ? '0 : g + SW'(1);

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        req_rot = {bus.req, bus.req} >> rr_ptr;
        pick    = '0;
        pidx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pidx = int'(rr_ptr) + k;
                if (pidx >= NREQ) pidx = pidx - NREQ;
                pick = SW'(pidx);
            end
        end
        for (int i = 0; i < NREQ; i++) pick_oh[i] = (pick == SW'(i));
    end

    always_comb begin
        g_dat  = '0;
        req_g  = 1'b0;
        in_rdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g == SW'(i)) begin
                g_dat  = bus.in_data[i*WIDTH +: WIDTH];
                req_g  = bus.req[i];
                in_rdy[i] = (state == OWN) && s0_free;
            end
        end
    end

    assign accept      = (state == OWN) && s0_free && req_g;
    assign release_own = (state == OWN) && (!req_g || (accept && last_beat));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (any_req)     state_n = OWN;
            OWN:     if (release_own) state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g      <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            gnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (state == IDLE && any_req) begin
            g      <= pick;
            gnt_q  <= pick_oh;
            busy_q <= 1'b1;
            cnt    <= '0;
        end else if (release_own) begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            cnt    <= '0;
            rr_ptr <= g_inc;
        end else if (accept) begin
            cnt    <= cnt + 8'd1;
        end
    end

    // s1 refills from s0 and s0 from the lane in the same edge, so a streaming grant never bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= '0;
            s1 <= '0;
        end else begin
            if (s1_load)                      s1     <= s0;
            else if (bus.out_ready && s1.vld) s1.vld <= 1'b0;

            if (accept)       s0     <= '{vld: 1'b1, dat: g_dat, src: g};
            else if (s1_load) s0.vld <= 1'b0;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = s1.vld;
    assign bus.out_data  = s1.dat;
    assign bus.out_src   = s1.src;
endmodule

// File: tb/tb_lane_arbiter.sv
// Directed bench for lane_arbiter (NREQ=4, WIDTH=1, MAX_BURST=4) with an in-order beat scoreboard.
module tb_lane_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 1;
    localparam int SW    = 2;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [SW-1:0]    src;
    } beat_t;

    logic  clk;
    logic  rst_n;
    int    n_vec;
    int    n_err;
    beat_t sb[$];

    lane_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    lane_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted beat is queued; every delivered beat must match the head of the queue.
    initial begin
        beat_t exp_b;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                sb.delete();
            end else begin
                for (int i = 0; i < NREQ; i++)
                    if (bus.req[i] && bus.in_ready[i])
                        sb.push_back('{dat: bus.in_data[i*WIDTH +: WIDTH], src: SW'(i)});
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("sb_extra", 32'(bus.out_valid), 0);
                    end else begin
                        exp_b = sb.pop_front();
                        check("sb_data", 32'(bus.out_data), 32'(exp_b.dat));
                        check("sb_src", 32'(bus.out_src), 32'(exp_b.src));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_vec %0d", n_vec);
        $fatal(1);
    end

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_gnt", 32'(bus.gnt), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_vld", 32'(bus.out_valid), 0);
            check("rst_rdy", 32'(bus.in_ready), 0);
        end
        rst_n   = 1'b1;
        bus.req = '0;
    endtask

    task automatic drain();
        tick();
        bus.req       = '0;
        bus.out_ready = 1'b1;
        repeat (6) tick();
        check("drain_gnt", 32'(bus.gnt), 0);
        check("drain_vld", 32'(bus.out_valid), 0);
        check("drain_sb", 32'(sb.size()), 0);
    endtask

    logic [3:0]  exp_gnt2 [8] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000};
    logic        exp_ov2  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0]  exp_rdy2 [8] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100};
    logic        d2       [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  exp_gnt5 [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};
    logic [3:0]  req5     [5] = '{4'b1011, 4'b1011, 4'b1001, 4'b1001, 4'b1001};
    logic [3:0]  exp_rdy5 [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};

    initial begin
        int         idx;
        int         acc;
        int         pos;
        logic [3:0] exp_g;
        logic [3:0] exp_r;
        logic [15:0] pat;

        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset with all requests pending, then first grant to requester 0.
        apply_reset();
        bus.req = 4'b1111;
        #1;
        check("t1_idle_rdy", 32'(bus.in_ready), 0);
        tick();
        check("t1_gnt", 32'(bus.gnt), 'b0001);
        check("t1_busy", 32'(bus.busy), 1);
        drain();

        // Single requester: 4-beat burst, one idle cycle, regrant for the fifth beat.
        apply_reset();
        idx         = 0;
        bus.req     = 4'b0100;
        bus.in_data = {1'b0, d2[0], 2'b00};
        for (int c = 0; c < 8; c++) begin
            #1;
            check("t2_rdy", 32'(bus.in_ready), 32'(exp_rdy2[c]));
            if (bus.req[2] && bus.in_ready[2]) idx++;
            tick();
            check("t2_gnt", 32'(bus.gnt), 32'(exp_gnt2[c]));
            check("t2_vld", 32'(bus.out_valid), 32'(exp_ov2[c]));
            if (idx < 5) begin
                bus.in_data = {1'b0, d2[idx], 2'b00};
            end else begin
                bus.req     = '0;
                bus.in_data = '0;
            end
        end
        check("t2_beats", 32'(idx), 5);
        drain();

        // All requesters: grants rotate 0,1,2,3,0 with 4 beats each and a 1-cycle gap.
        apply_reset();
        bus.req = 4'b1111;
        #1;
        for (int e = 1; e <= 21; e++) begin
            tick();
            pos   = (e - 1) % 5;
            exp_g = (pos < 4) ? (4'b0001 << (((e - 1) / 5) % 4)) : 4'b0000;
            check("t3_gnt", 32'(bus.gnt), 32'(exp_g));
            bus.in_data = 4'(e * 7);
            #1;
            check("t3_rdy", 32'(bus.in_ready), 32'(exp_g));
        end
        drain();

        // Backpressure: out_ready low for 5 cycles after the first beat; stall does not count.
        apply_reset();
        bus.req = 4'b0001;
        acc     = 0;
        pat     = 16'h02FA;
        for (int c = 1; c <= 9; c++) begin
            tick();
            check("t4_gnt", 32'(bus.gnt), (c <= 8) ? 'b0001 : 'b0000);
            if (c >= 3 && c <= 7) begin
                check("t4_hold_vld", 32'(bus.out_valid), 1);
                check("t4_hold_dat", 32'(bus.out_data), 1);
            end
            bus.out_ready = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            bus.in_data   = {3'b000, pat[c]};
            #1;
            exp_r = (c <= 2 || c == 7 || c == 8) ? 4'b0001 : 4'b0000;
            check("t4_rdy", 32'(bus.in_ready), 32'(exp_r));
            if (bus.req[0] && bus.in_ready[0]) acc++;
        end
        check("t4_acc", 32'(acc), 4);
        drain();

        // Early release: req[1] drops after 2 beats; rr_ptr=2 so requester 3 wins over 0.
        apply_reset();
        bus.req     = 4'b0010;
        bus.in_data = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t5_gnt", 32'(bus.gnt), 32'(exp_gnt5[c]));
            bus.req     = req5[c];
            bus.in_data = 4'(c * 5 + 2);
            #1;
            check("t5_rdy", 32'(bus.in_ready), 32'(exp_rdy5[c]));
        end
        drain();

        // Reset with both stages full after a release; rr_ptr returns to 0, no stale beats.
        apply_reset();
        bus.req       = 4'b0001;
        bus.out_ready = 1'b0;
        bus.in_data   = 4'b0000;
        tick();
        check("t6_gnt", 32'(bus.gnt), 'b0001);
        bus.in_data = 4'b0001;
        tick();
        bus.in_data = 4'b0000;
        tick();
        check("t6_full_vld", 32'(bus.out_valid), 1);
        bus.req = '0;
        #1;
        check("t6_full_rdy", 32'(bus.in_ready), 0);
        tick();
        check("t6_rel_gnt", 32'(bus.gnt), 0);
        check("t6_rel_vld", 32'(bus.out_valid), 1);
        check("t6_rel_dat", 32'(bus.out_data), 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_vld", 32'(bus.out_valid), 0);
        check("t6_rst_gnt", 32'(bus.gnt), 0);
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_rdy", 32'(bus.in_ready), 0);
        tick();
        rst_n         = 1'b1;
        bus.req       = 4'b1111;
        bus.out_ready = 1'b1;
        tick();
        check("t6_regnt", 32'(bus.gnt), 'b0001);
        check("t6_vld_a", 32'(bus.out_valid), 0);
        tick();
        check("t6_vld_b", 32'(bus.out_valid), 0);
        tick();
        check("t6_vld_c", 32'(bus.out_valid), 1);
        check("t6_src", 32'(bus.out_src), 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
